// File: rtl/regfile_scb_if.sv
// rtl/regfile_scb_if.sv - port bundle for regfile_scb (write/reserve/read/clear signals).
// The debug signals exist only when REGFILE_SCB_DBG_EN is defined.
interface regfile_scb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) ();
  logic              wr0_en;
  logic [ADDR_W-1:0] wr0_addr;
  logic [DATA_W-1:0] wr0_data;
  logic              wr1_en;
  logic [ADDR_W-1:0] wr1_addr;
  logic [DATA_W-1:0] wr1_data;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic              clr_req;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_pend_a;
  logic              rd_pend_b;
  logic              busy;
`ifdef REGFILE_SCB_DBG_EN
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [15:0]       wr_count;

  modport master (
    output wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           rsv_en, rsv_addr, clr_req, rd_addr_a, rd_addr_b, dbg_addr,
    input  rd_data_a, rd_data_b, rd_pend_a, rd_pend_b, busy, dbg_data, wr_count
  );
  modport slave (
    input  wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           rsv_en, rsv_addr, clr_req, rd_addr_a, rd_addr_b, dbg_addr,
    output rd_data_a, rd_data_b, rd_pend_a, rd_pend_b, busy, dbg_data, wr_count
  );
`else
  modport master (
    output wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           rsv_en, rsv_addr, clr_req, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, rd_pend_a, rd_pend_b, busy
  );
  modport slave (
    input  wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           rsv_en, rsv_addr, clr_req, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, rd_pend_a, rd_pend_b, busy
  );
`endif
endinterface

// File: rtl/regfile_scb.sv
// rtl/regfile_scb.sv - 2W/2R register file with write bypass, pending scoreboard and clear engine.
// Optional debug read port and write counter under REGFILE_SCB_DBG_EN.
module regfile_scb #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int ZERO_R0 = 0
) (
  input logic          clk,
  input logic          reset,
  regfile_scb_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic              busy_q;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  pend_q;

  logic idle;
  logic wr0_acc;
  logic wr1_acc;
  logic rsv_acc;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return (ZERO_R0 != 0) && (addr == '0);
  endfunction

  assign idle    = (state_q == IDLE);
  assign wr0_acc = bus.wr0_en && idle && !is_zero_reg(bus.wr0_addr);
  assign wr1_acc = bus.wr1_en && idle && !is_zero_reg(bus.wr1_addr);
  assign rsv_acc = bus.rsv_en && idle && !is_zero_reg(bus.rsv_addr);

  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];
  logic              rd_pend [2];

  assign rd_addr[0]    = bus.rd_addr_a;
  assign rd_addr[1]    = bus.rd_addr_b;
  assign bus.rd_data_a = rd_data[0];
  assign bus.rd_data_b = rd_data[1];
  assign bus.rd_pend_a = rd_pend[0];
  assign bus.rd_pend_b = rd_pend[1];
  assign bus.busy      = busy_q;

  // wr1 is checked first so the read view matches the collision outcome.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = regs_q[rd_addr[p]];
      if (is_zero_reg(rd_addr[p])) begin
        rd_data[p] = '0;
      end else if (wr1_acc && (bus.wr1_addr == rd_addr[p])) begin
        rd_data[p] = bus.wr1_data;
      end else if (wr0_acc && (bus.wr0_addr == rd_addr[p])) begin
        rd_data[p] = bus.wr0_data;
      end
      rd_pend[p] = pend_q[rd_addr[p]] && !(wr1_acc && (bus.wr1_addr == rd_addr[p]));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      pend_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (wr0_acc) begin
            regs_q[bus.wr0_addr] <= bus.wr0_data;
          end
          if (wr1_acc) begin
            regs_q[bus.wr1_addr] <= bus.wr1_data;
            pend_q[bus.wr1_addr] <= 1'b0;
          end
          // Placed after the wr1 release so a same-cycle reservation wins.
          if (rsv_acc) begin
            pend_q[bus.rsv_addr] <= 1'b1;
          end
          if (bus.clr_req) begin
            state_q <= CLEAR;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          regs_q[idx_q] <= '0;
          pend_q[idx_q] <= 1'b0;
          idx_q         <= idx_q + ADDR_W'(1);
          if (idx_q == LAST_IDX) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef REGFILE_SCB_DBG_EN
  logic [15:0] wr_count_q;
  logic [15:0] wr_count_d;
  logic [16:0] wr_sum;

  always_comb begin
    wr_sum     = {1'b0, wr_count_q} + 17'(wr0_acc) + 17'(wr1_acc);
    wr_count_d = wr_sum[16] ? 16'hFFFF : wr_sum[15:0];
    if (idle && bus.clr_req) begin
      wr_count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  assign bus.wr_count = wr_count_q;
  assign bus.dbg_data = is_zero_reg(bus.dbg_addr) ? '0 : regs_q[bus.dbg_addr];
`endif
endmodule
